innerproduct_mac: RTL and testbench

- Parametrised, time-multiplexed successor to the fully combinational 81-term inner product used by the logistic-regression classifier.
- Accepts one unsigned pixel per cycle over a valid/ready stream and multiplies it by a signed weight from a run-time loadable weight bank.
- Accumulates the products and emits one hprime word per feature vector over a valid/ready output.
- Sits between the line buffer (pixel source) and the sigmoid/threshold stage.

---
 rtl/innerproduct_mac.sv | 76 +++++++
 tb/tb_innerproduct_mac.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/innerproduct_mac.sv
// innerproduct_mac: streaming inner product of unsigned pixels with a loadable signed weight bank
//   clk, rst_n                   clock, asynchronous active-low reset
//   i_x_valid/o_x_ready/i_x_data pixel stream, one unsigned pixel per handshake
//   i_w_we/i_w_addr/i_w_data     weight bank write port, accepted only while idle
//   o_y_valid/i_y_ready/o_y_data one signed inner product per feature vector
//   o_busy                       vector in progress or result pending
module innerproduct_mac #(
  parameter int N_FEAT  = 81,
  parameter int X_W     = 7,
  parameter int THETA_W = 16,
  parameter int ACC_W   = 32,
  parameter int AW      = $clog2(N_FEAT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_x_valid,
  output logic               o_x_ready,
  input  logic [X_W-1:0]     i_x_data,
  input  logic               i_w_we,
  input  logic [AW-1:0]      i_w_addr,
  input  logic [THETA_W-1:0] i_w_data,
  output logic               o_y_valid,
  input  logic               i_y_ready,
  output logic [ACC_W-1:0]   o_y_data,
  output logic               o_busy
);
  localparam int PW = X_W + 1 + THETA_W;
  // product is formed at least ACC_W wide so the low ACC_W bits are the sign-extended (or wrapped) term
  localparam int EW = (PW > ACC_W) ? PW : ACC_W;
  typedef enum logic {ACCUM, DONE} state_t;
  state_t                    r_state;
  logic [AW-1:0]             r_cnt;
  logic [ACC_W-1:0]          r_acc;
  logic [ACC_W-1:0]          r_y;
  logic signed [THETA_W-1:0] r_w [N_FEAT];
  logic signed [X_W:0]       w_x_s;
  logic signed [EW-1:0]      w_prod;
  logic [ACC_W-1:0]          w_sum;
  logic                      w_x_hs;
  logic                      w_y_hs;
  logic                      w_last;
  logic                      w_we_ok;
  assign o_x_ready = r_state == ACCUM;
  assign o_y_valid = r_state == DONE;
  assign o_y_data  = r_y;
  assign o_busy    = (r_state == DONE) || (r_cnt != '0);
  assign w_x_hs    = i_x_valid && o_x_ready;
  assign w_y_hs    = o_y_valid && i_y_ready;
  assign w_last    = r_cnt == AW'(N_FEAT - 1);
  assign w_we_ok   = i_w_we && !o_busy && (32'(i_w_addr) < N_FEAT);
  assign w_x_s     = {1'b0, i_x_data};
  assign w_prod    = EW'(w_x_s) * EW'(r_w[r_cnt]);
  // first term of a vector restarts the sum instead of adding to the previous result
  assign w_sum     = (r_cnt == '0) ? w_prod[ACC_W-1:0] : r_acc + w_prod[ACC_W-1:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACCUM;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_y     <= '0;
      for (int i = 0; i < N_FEAT; i++) r_w[i] <= '0;
    end else begin
      if (w_x_hs) begin
        r_acc <= w_sum;
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        if (w_last) begin
          r_state <= DONE;
          r_y     <= w_sum;
        end
      end
      if (w_y_hs) r_state <= ACCUM;
      // bank is read combinationally above, so a write at cnt=0 lands after pixel 0 used the old weight
      if (w_we_ok) r_w[i_w_addr] <= i_w_data;
    end
  end
endmodule

// File: tb/tb_innerproduct_mac.sv
// tb_innerproduct_mac: directed checks of the streaming inner-product MAC
module tb_innerproduct_mac;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  logic a_x_valid = 0, a_x_ready, a_w_we = 0, a_y_valid, a_y_ready = 0, a_busy;
  logic [6:0] a_x_data = 0, a_w_addr = 0;
  logic [15:0] a_w_data = 0;
  logic signed [31:0] a_y_data;
  innerproduct_mac dut_a (
    .clk(clk), .rst_n(rst_n), .i_x_valid(a_x_valid), .o_x_ready(a_x_ready), .i_x_data(a_x_data),
    .i_w_we(a_w_we), .i_w_addr(a_w_addr), .i_w_data(a_w_data), .o_y_valid(a_y_valid),
    .i_y_ready(a_y_ready), .o_y_data(a_y_data), .o_busy(a_busy));

  logic b_x_valid = 0, b_x_ready, b_w_we = 0, b_y_valid, b_y_ready = 0, b_busy;
  logic [6:0] b_x_data = 0;
  logic [2:0] b_w_addr = 0;
  logic [15:0] b_w_data = 0;
  logic signed [31:0] b_y_data;
  innerproduct_mac #(.N_FEAT(4), .AW(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_x_valid(b_x_valid), .o_x_ready(b_x_ready), .i_x_data(b_x_data),
    .i_w_we(b_w_we), .i_w_addr(b_w_addr), .i_w_data(b_w_data), .o_y_valid(b_y_valid),
    .i_y_ready(b_y_ready), .o_y_data(b_y_data), .o_busy(b_busy));

  logic c_x_valid = 0, c_x_ready, c_w_we = 0, c_y_valid, c_y_ready = 0, c_busy;
  logic [6:0] c_x_data = 0;
  logic [1:0] c_w_addr = 0;
  logic [15:0] c_w_data = 0;
  logic signed [15:0] c_y_data;
  innerproduct_mac #(.N_FEAT(4), .ACC_W(16)) dut_c (
    .clk(clk), .rst_n(rst_n), .i_x_valid(c_x_valid), .o_x_ready(c_x_ready), .i_x_data(c_x_data),
    .i_w_we(c_w_we), .i_w_addr(c_w_addr), .i_w_data(c_w_data), .o_y_valid(c_y_valid),
    .i_y_ready(c_y_ready), .o_y_data(c_y_data), .o_busy(c_busy));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic b_load(input int w0, input int w1, input int w2, input int w3);
    int wv[4];
    wv = '{w0, w1, w2, w3};
    for (int i = 0; i < 4; i++) begin
      b_w_we = 1; b_w_addr = 3'(i); b_w_data = 16'(wv[i]);
      step();
    end
    b_w_we = 0;
  endtask

  task automatic b_push(input int x);
    int n = 0;
    b_x_valid = 1; b_x_data = 7'(x);
    while (!b_x_ready && n < 50) begin step(); n++; end
    step();
    b_x_valid = 0;
  endtask

  task automatic b_pop();
    int n = 0;
    while (!b_y_valid && n < 50) begin step(); n++; end
    checks++;
    if (!b_y_valid) begin errors++; $display("FAIL pop_timeout y_valid=%0b required 1", b_y_valid); end
    b_y_ready = 1; step(); b_y_ready = 0;
  endtask

  task automatic test_reset();
    repeat (2) step();
    rst_n = 1;
    step();
    checks++; if (b_y_valid !== 1'b0) begin errors++; $display("FAIL reset_y_valid got %0b exp 0", b_y_valid); end
    checks++; if (b_y_data !== 0) begin errors++; $display("FAIL reset_y_data got %0d exp 0", b_y_data); end
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", b_busy); end
    checks++; if (b_x_ready !== 1'b1) begin errors++; $display("FAIL reset_x_ready got %0b exp 1", b_x_ready); end
  endtask

  task automatic test_full_vector();
    for (int i = 0; i < 81; i++) begin
      a_w_we = 1; a_w_addr = 7'(i); a_w_data = 16'd1;
      step();
    end
    a_w_we = 0;
    a_x_valid = 1; a_x_data = 7'd127;
    repeat (81) step();
    a_x_valid = 0;
    checks++; if (a_y_valid !== 1'b1) begin errors++; $display("FAIL full_y_valid got %0b exp 1", a_y_valid); end
    checks++; if (a_y_data !== 10287) begin errors++; $display("FAIL full_y_data got %0d exp 10287", a_y_data); end
    checks++; if (a_x_ready !== 1'b0) begin errors++; $display("FAIL full_x_ready_done got %0b exp 0", a_x_ready); end
    a_y_ready = 1; step(); a_y_ready = 0;
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL full_busy_after got %0b exp 0", a_busy); end
    checks++; if (a_y_valid !== 1'b0) begin errors++; $display("FAIL full_y_valid_after got %0b exp 0", a_y_valid); end
    checks++; if (a_y_data !== 10287) begin errors++; $display("FAIL full_y_hold got %0d exp 10287", a_y_data); end
  endtask

  task automatic test_signed();
    b_load(-3, 5, -32768, 32767);
    b_push(10); b_push(0); b_push(1); b_push(127);
    checks++; if (b_y_valid !== 1'b1) begin errors++; $display("FAIL signed_latency y_valid got %0b exp 1", b_y_valid); end
    checks++; if (b_y_data !== 4128611) begin errors++; $display("FAIL signed_v1 got %0d exp 4128611", b_y_data); end
    b_pop();
    b_push(1); b_push(0); b_push(0); b_push(0);
    checks++; if (b_y_data !== -3) begin errors++; $display("FAIL signed_restart got %0d exp -3", b_y_data); end
    b_pop();
  endtask

  task automatic test_backpressure();
    int xv[4];
    xv = '{3, 50, 2, 100};
    for (int i = 0; i < 4; i++) begin
      b_x_valid = 0;
      repeat ($urandom_range(0, 3)) step();
      b_push(xv[i]);
    end
    for (int k = 0; k < 5; k++) begin
      b_x_valid = 1; b_x_data = 7'd99;
      checks++; if (b_x_ready !== 1'b0) begin errors++; $display("FAIL bp_x_ready cycle %0d got %0b exp 0", k, b_x_ready); end
      checks++; if (b_y_data !== 3211405) begin errors++; $display("FAIL bp_y_stable cycle %0d got %0d exp 3211405", k, b_y_data); end
      step();
    end
    b_x_valid = 0;
    checks++; if (b_y_valid !== 1'b1) begin errors++; $display("FAIL bp_y_valid_held got %0b exp 1", b_y_valid); end
    b_pop();
    checks++; if (b_x_ready !== 1'b1) begin errors++; $display("FAIL bp_x_ready_after got %0b exp 1", b_x_ready); end
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL bp_busy_after got %0b exp 0", b_busy); end
  endtask

  task automatic test_write_gating();
    b_push(1); b_push(1);
    b_w_we = 1; b_w_addr = 3'd2; b_w_data = 16'd100;
    step();
    b_w_we = 0;
    b_push(1); b_push(1);
    checks++; if (b_y_data !== 1) begin errors++; $display("FAIL gate_busy_write got %0d exp 1", b_y_data); end
    b_pop();
    b_w_we = 1; b_w_addr = 3'd5; b_w_data = 16'd100;
    step();
    b_w_we = 0;
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL gate_oob_busy got %0b exp 0", b_busy); end
    b_w_we = 1; b_w_addr = 3'd0; b_w_data = 16'd7;
    b_push(2);
    b_w_we = 0;
    b_push(0); b_push(0); b_push(0);
    checks++; if (b_y_data !== -6) begin errors++; $display("FAIL gate_rbw_old got %0d exp -6", b_y_data); end
    b_pop();
    b_push(1); b_push(0); b_push(0); b_push(0);
    checks++; if (b_y_data !== 7) begin errors++; $display("FAIL gate_rbw_new got %0d exp 7", b_y_data); end
    b_pop();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) begin
      c_w_we = 1; c_w_addr = 2'(i); c_w_data = 16'd32767;
      step();
    end
    c_w_we = 0;
    c_x_valid = 1; c_x_data = 7'd127;
    repeat (4) step();
    c_x_valid = 0;
    checks++; if (c_y_valid !== 1'b1) begin errors++; $display("FAIL wrap_y_valid got %0b exp 1", c_y_valid); end
    checks++; if (c_y_data !== -16'sd508) begin errors++; $display("FAIL wrap_y_data got %0d exp -508", c_y_data); end
    c_y_ready = 1; step(); c_y_ready = 0;
    checks++; if (c_busy !== 1'b0) begin errors++; $display("FAIL wrap_busy_after got %0b exp 0", c_busy); end
  endtask

  task automatic test_reset_mid();
    b_push(1); b_push(1);
    rst_n = 0;
    #1;
    checks++; if (b_y_valid !== 1'b0) begin errors++; $display("FAIL rstmid_y_valid got %0b exp 0", b_y_valid); end
    checks++; if (b_y_data !== 0) begin errors++; $display("FAIL rstmid_y_data got %0d exp 0", b_y_data); end
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %0b exp 0", b_busy); end
    step();
    rst_n = 1;
    step();
    b_push(5); b_push(6); b_push(7); b_push(8);
    checks++; if (b_y_data !== 0) begin errors++; $display("FAIL rstmid_zero_weights got %0d exp 0", b_y_data); end
    b_pop();
    b_load(1, 1, 1, 1);
    b_push(5); b_push(6); b_push(7); b_push(8);
    checks++; if (b_y_data !== 26) begin errors++; $display("FAIL rstmid_reload got %0d exp 26", b_y_data); end
    b_pop();
  endtask

  initial begin
    test_reset();
    test_full_vector();
    test_signed();
    test_backpressure();
    test_write_gating();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
